mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 5-stage RV32I pipeline, directly downstream of the execute stage.
- Consumes the EX→MEM pipeline register outputs and drives a ready/valid data-memory port with byte-lane alignment and load extension.
- Stalls the front of the pipeline while memory is busy.
- Produces the registered MEM→WB write-back value, which is also the WB forwarding source.

## Interface
Parameters:
- `ADDR_W`, 32, data-memory byte-address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `regwrite_EX`  in  1  instruction writes rd.
- `datawe_EX`  in  1  instruction is a store.
- `wbsel_EX`  in  3  write-back source: 000 ALU, 001 load, 010 pcnext, 011 imm (LUI), 100 pc+imm (AUIPC); others treated as 000.
- `strb_EX`  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `rd_EX`  in  5  destination register.
- `aluout_EX`  in  32  effective address / ALU result.
- `rdata2_EX`  in  32  store data (already forwarded).
- `immext_EX`, `pcimmaui_EX`, `pcnext_EX`  in  32 each  alternative write-back values.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  ADDR_W  word-aligned address (`aluout_EX` with [1:0]=0).
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rdata`  in  32  read data, valid when `dmem_ready`.
- `dmem_ready`  in  1  access completes this cycle.
- `stall_MEM`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers.
- `misalign_MEM`  out  1  one-cycle pulse: misaligned access suppressed.
- `regwrite_MEM`  out  1  WB write enable.
- `rd_MEM`  out  5  WB destination.
- `wdata_MEM`  out  32  WB data (forwarding source `fdata_WB`).

## Operation
- Memory op = `datawe_EX` or `wbsel_EX`==001.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00. A misaligned access is never issued. Instead, `misalign_MEM` pulses, WB gets a bubble (`regwrite_MEM`=0), and the instruction retires.
- Store lanes:
  - B: `dmem_be` = 0001<<addr[1:0], wdata = byte replicated ×4.
  - H: `dmem_be` = 0011<<addr[1:0], wdata = half replicated ×2.
  - W: `dmem_be` = 1111, wdata = `rdata2_EX`.
- Load extraction uses addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- FSM, 2 states:
  - IDLE: a valid aligned memory op drives `dmem_req`=1.
    - If `dmem_ready`=1 the same cycle, the op completes with zero wait and the state stays IDLE.
    - Otherwise go to WAIT.
  - WAIT: hold `dmem_req` and every `dmem_*` output stable, and keep `stall_MEM`=1.
    - On `dmem_ready`=1, complete and return to IDLE.
- `stall_MEM` = memory op in flight AND NOT `dmem_ready` (combinational, active in both IDLE and WAIT). Upstream holds the EX/MEM register stable while it is high.
- Non-memory ops: `dmem_req`=0, no stall.
- MEM→WB register update:
  - On completion (or on any non-memory op), load `regwrite_MEM`=`regwrite_EX` & ~`datawe_EX` & (`rd_EX`≠0), `rd_MEM`=`rd_EX`, and `wdata_MEM` = the selected source.
  - During stall cycles, load a bubble: `regwrite_MEM`=0, `rd_MEM`=0; `wdata_MEM` holds.

## Timing
- Reset values: FSM IDLE; `regwrite_MEM`=0, `rd_MEM`=0, `wdata_MEM`=0; `dmem_req`=0, `stall_MEM`=0, `misalign_MEM`=0.
- Non-memory op: result is visible in the MEM→WB register 1 cycle after it appears on the EX inputs.
- Memory op with N wait cycles: stall held N cycles; WB result appears the edge after `dmem_ready`.
- `dmem_ready` while `dmem_req`=0 is ignored.
- Reset mid-WAIT: the next edge returns to IDLE and drops `dmem_req`. The pending transaction is abandoned; memory must tolerate this.
- Store then load to the same address with no stall: the load is issued the next cycle. Ordering is guaranteed by the in-order single-request port.
- `rd`=x0 load: the access is performed but nothing is written back.

## Structure
- Shared package `isa_pkg`: wbsel codes, strb size codes, `mem_state_t` enum.
- One sub-module, `mem_lane_align`: combinational store-lane generation and load extraction, parameterless, reusable by a future cache.

## Test plan
- ADD result 0x0000_1234, wbsel 000, rd=5 → next cycle `regwrite_MEM`=1, `rd_MEM`=5, `wdata_MEM`=0x0000_1234, `dmem_req`=0.
- SB addr 0x103, `rdata2_EX`=0x0000_00A5, ready tied 1 → `dmem_be`=1000, `dmem_wdata`=0xA5A5_A5A5, `dmem_addr`=0x100, no stall, `regwrite_MEM`=0.
- LH addr 0x202, memory word 0x8001_7FFF, ready after 3 cycles → `stall_MEM` high 3 cycles with WB bubbles, then `wdata_MEM`=0xFFFF_8001. LHU on the same word → 0x0000_8001.
- LW addr 0x306 → `misalign_MEM` pulse, `dmem_req`=0, `regwrite_MEM`=0, no stall.
- LW in WAIT, `rst` asserted 1 cycle → next edge IDLE, `dmem_req`=0, `stall_MEM`=0, all WB outputs 0.
- AUIPC wbsel 100, `pcimmaui_EX`=0x0000_4010 → `wdata_MEM`=0x0000_4010. LUI with rd=0 → `regwrite_MEM`=0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared RV32I pipeline encodings: write-back source codes, load/store size codes, MEM FSM states.
package isa_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] WB_ALU    = 3'b000;
  localparam logic [2:0] WB_LOAD   = 3'b001;
  localparam logic [2:0] WB_PCNEXT = 3'b010;
  localparam logic [2:0] WB_IMM    = 3'b011;
  localparam logic [2:0] WB_AUIPC  = 3'b100;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane store alignment, load extraction/extension and misalignment detection.
module mem_lane_align
  import isa_pkg::*;
(
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      strb_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] load_word_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = load_word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];

  always_comb begin
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = load_word_i;
    misalign_o  = 1'b0;
    case (strb_i)
      SZ_B, SZ_BU: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = (strb_i == SZ_B) ? {{24{byte_sel[7]}}, byte_sel}
                                       : {24'h000000, byte_sel};
      end
      SZ_H, SZ_HU: begin
        be_o        = 4'b0011 << addr_lo_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = (strb_i == SZ_H) ? {{16{half_sel[15]}}, half_sel}
                                       : {16'h0000, half_sel};
        misalign_o  = addr_lo_i[0];
      end
      SZ_W: misalign_o = (addr_lo_i != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: ready/valid data-memory port, front-end stall, registered MEM->WB result.
module mem_stage
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite_EX,
  input  logic              datawe_EX,
  input  logic [2:0]        wbsel_EX,
  input  logic [2:0]        strb_EX,
  input  logic [4:0]        rd_EX,
  input  logic [XLEN-1:0]   aluout_EX,
  input  logic [XLEN-1:0]   rdata2_EX,
  input  logic [XLEN-1:0]   immext_EX,
  input  logic [XLEN-1:0]   pcimmaui_EX,
  input  logic [XLEN-1:0]   pcnext_EX,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall_MEM,
  output logic              misalign_MEM,
  output logic              regwrite_MEM,
  output logic [4:0]        rd_MEM,
  output logic [XLEN-1:0]   wdata_MEM
);

  mem_state_t      state_q, state_d;
  logic            mem_op, misalign, valid_op;
  logic [XLEN-1:0] load_data, wb_value;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            misalign_q, misalign_d;

  assign mem_op   = datawe_EX | (wbsel_EX == WB_LOAD);
  assign valid_op = mem_op & ~misalign;

  mem_lane_align u_align (
    .addr_lo_i    (aluout_EX[1:0]),
    .strb_i       (strb_EX),
    .store_data_i (rdata2_EX),
    .load_word_i  (dmem_rdata),
    .be_o         (dmem_be),
    .wdata_o      (dmem_wdata),
    .load_data_o  (load_data),
    .misalign_o   (misalign)
  );

  // EX/MEM is frozen while stalled, so address/data stay stable through WAIT.
  assign dmem_addr = ADDR_W'({aluout_EX[31:2], 2'b00});
  assign dmem_we   = dmem_req & datawe_EX;

  always_comb begin
    case (wbsel_EX)
      WB_LOAD:   wb_value = load_data;
      WB_PCNEXT: wb_value = pcnext_EX;
      WB_IMM:    wb_value = immext_EX;
      WB_AUIPC:  wb_value = pcimmaui_EX;
      default:   wb_value = aluout_EX;
    endcase
  end

  // Next-state, request/stall generation and MEM->WB next values.
  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    stall_MEM  = 1'b0;
    regwrite_d = regwrite_EX & ~datawe_EX & (rd_EX != 5'd0);
    rd_d       = rd_EX;
    wdata_d    = wb_value;
    misalign_d = mem_op & misalign;
    case (state_q)
      MEM_IDLE: begin
        if (valid_op) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            stall_MEM = 1'b1;
            state_d   = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) state_d = MEM_IDLE;
        else            stall_MEM = 1'b1;
      end
      default: state_d = MEM_IDLE;
    endcase
    if (stall_MEM || misalign_d) begin
      regwrite_d = 1'b0;
      rd_d       = 5'd0;
      wdata_d    = wdata_q;
    end
    if (rst) begin
      state_d   = MEM_IDLE;
      dmem_req  = 1'b0;
      stall_MEM = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_IDLE;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
    end
  end

  assign regwrite_MEM = regwrite_q;
  assign rd_MEM       = rd_q;
  assign wdata_MEM    = wdata_q;
  assign misalign_MEM = misalign_q;

endmodule
